bus_xfer_ctrl: RTL and testbench

BUS_XFER_CTRL -- requirements
Module: bus_xfer_ctrl

---
 rtl/bus_xfer_pkg.sv | 36 +++
 rtl/bus_src_mux.sv | 31 +++
 rtl/bus_xfer_ctrl.sv | 167 ++++++++++++++++
 tb/tb_bus_xfer_ctrl.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/bus_xfer_pkg.sv
// -----------------------------------------------------------------------------
// bus_xfer_pkg
// Shared definitions for the register-to-register bus transfer controller:
// default geometry, operation encodings, controller states and a helper that
// sizes register-index fields.
// Optional feature macro used by the controller: XFER_STATS_EN.
// -----------------------------------------------------------------------------
package bus_xfer_pkg;

    localparam int NREG_DEF = 8;   // attached registers
    localparam int W_DEF    = 16;  // bus / register data width

    typedef enum logic [1:0] {
        OP_MOVE     = 2'b00,  // dst <= src
        OP_INC      = 2'b01,  // dst <= dst + 1
        OP_CLR      = 2'b10,  // dst <= 0
        OP_MOVE_INC = 2'b11   // dst <= src, then src <= src + 1
    } op_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_CAPT,
        ST_WRITE,
        ST_INCS,
        ST_INCD,
        ST_CLRD,
        ST_FIN
    } state_t;

    // Width of a register index; a single register still needs one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/bus_src_mux.sv
// -----------------------------------------------------------------------------
// bus_src_mux
// NREG:1 multiplexer picking one W-bit register output word from the
// concatenated read bus.
// Ports:
//   rdata  in   NREG*W  register i output word at bits [i*W +: W]
//   sel    in   IW      register index
//   data   out  W       selected word
// -----------------------------------------------------------------------------
module bus_src_mux
    import bus_xfer_pkg::*;
#(
    parameter int NREG = NREG_DEF,
    parameter int W    = W_DEF,
    localparam int IW  = idx_width(NREG)
) (
    input  logic [NREG*W-1:0] rdata,
    input  logic [IW-1:0]     sel,
    output logic [W-1:0]      data
);

    always_comb begin
        data = '0;
        for (int i = 0; i < NREG; i++) begin
            if (sel == IW'(i)) begin
                data = rdata[i*W +: W];
            end
        end
    end

endmodule

// File: rtl/bus_xfer_ctrl.sv
// -----------------------------------------------------------------------------
// bus_xfer_ctrl
// Sequences single-bus register transfers (move, increment, clear, move with
// source post-increment) by issuing one-hot strobes to NREG attached registers.
// Source data is captured through bus_src_mux into an internal bus latch that
// drives BIN.
// Optional feature: define XFER_STATS_EN to add XFER_CNT, a wrapping 16-bit
// count of completed transfers.
// Ports:
//   clk       in   1       clock, rising edge
//   RST       in   1       asynchronous active-high reset
//   REQ       in   1       transfer request, sampled only when idle
//   OP        in   2       operation (see op_t)
//   SRC, DST  in   IW      source / destination register index
//   RDATA     in   NREG*W  concatenated register output words
//   LDBUS     out  NREG    one-hot: source drives its value onto the bus
//   WR        out  NREG    one-hot: destination writes BIN
//   INC       out  NREG    one-hot increment strobe
//   CLR       out  NREG    one-hot clear strobe
//   BIN       out  W       write data to all registers (bus latch)
//   BUSY      out  1       transfer in progress
//   DONE      out  1       one-cycle completion pulse
//   XFER_CNT  out  16      completed transfers (XFER_STATS_EN only)
// -----------------------------------------------------------------------------
module bus_xfer_ctrl
    import bus_xfer_pkg::*;
#(
    parameter int NREG = NREG_DEF,
    parameter int W    = W_DEF,
    localparam int IW  = idx_width(NREG)
) (
    input  logic              clk,
    input  logic              RST,
    input  logic              REQ,
    input  logic [1:0]        OP,
    input  logic [IW-1:0]     SRC,
    input  logic [IW-1:0]     DST,
    input  logic [NREG*W-1:0] RDATA,
    output logic [NREG-1:0]   LDBUS,
    output logic [NREG-1:0]   WR,
    output logic [NREG-1:0]   INC,
    output logic [NREG-1:0]   CLR,
    output logic [W-1:0]      BIN,
    output logic              BUSY,
    output logic              DONE
`ifdef XFER_STATS_EN
    ,
    output logic [15:0]       XFER_CNT
`endif
);

    state_t        state_q, state_d;
    op_t           op_q;
    logic [IW-1:0] src_q, dst_q;
    logic [W-1:0]  bus_latch;
    logic [W-1:0]  mux_data;

    bus_src_mux #(
        .NREG (NREG),
        .W    (W)
    ) u_src_mux (
        .rdata (RDATA),
        .sel   (src_q),
        .data  (mux_data)
    );

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Command registers and bus latch. The latch is reset as well so BIN is a
    // defined value from reset onward, not just after the first move.
    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            op_q      <= OP_MOVE;
            src_q     <= '0;
            dst_q     <= '0;
            bus_latch <= '0;
        end else begin
            // Indices are captured only on acceptance; REQ and index changes
            // while busy have no effect on the transfer in flight.
            if (state_q == ST_IDLE && REQ) begin
                op_q  <= op_t'(OP);
                src_q <= SRC;
                dst_q <= DST;
            end
            if (state_q == ST_CAPT) begin
                bus_latch <= mux_data;
            end
        end
    end

    // Next state and strobe decode. Strobes depend only on the registered
    // state, so an asynchronous reset removes them immediately.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves a value unassigned and no latch is inferred.
        state_d = state_q;
        LDBUS   = '0;
        WR      = '0;
        INC     = '0;
        CLR     = '0;
        DONE    = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (REQ) begin
                    unique case (op_t'(OP))
                        OP_INC:  state_d = ST_INCD;
                        OP_CLR:  state_d = ST_CLRD;
                        default: state_d = ST_LOAD;
                    endcase
                end
            end
            ST_LOAD: begin
                LDBUS[src_q] = 1'b1;
                state_d      = ST_CAPT;
            end
            ST_CAPT: begin
                state_d = ST_WRITE;
            end
            ST_WRITE: begin
                WR[dst_q] = 1'b1;
                state_d   = (op_q == OP_MOVE_INC) ? ST_INCS : ST_FIN;
            end
            ST_INCS: begin
                INC[src_q] = 1'b1;
                state_d    = ST_FIN;
            end
            ST_INCD: begin
                INC[dst_q] = 1'b1;
                state_d    = ST_FIN;
            end
            ST_CLRD: begin
                CLR[dst_q] = 1'b1;
                state_d    = ST_FIN;
            end
            ST_FIN: begin
                DONE    = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign BUSY = (state_q != ST_IDLE);
    assign BIN  = bus_latch;

`ifdef XFER_STATS_EN
    // Counts completions; FIN is the only state that raises DONE.
    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            XFER_CNT <= '0;
        end else if (state_q == ST_FIN) begin
            XFER_CNT <= XFER_CNT + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_bus_xfer_ctrl.sv
// -----------------------------------------------------------------------------
// tb_bus_xfer_ctrl
// Self-checking bench for bus_xfer_ctrl. A reference model expands each
// transfer into the cycle-by-cycle output pattern it must produce; the bench
// drives inputs on the falling edge and compares outputs there.
// Honours XFER_STATS_EN when defined.
// -----------------------------------------------------------------------------
module tb_bus_xfer_ctrl;

    localparam int NREG = 8;
    localparam int W    = 16;

    typedef struct {
        logic [NREG-1:0] ldbus;
        logic [NREG-1:0] wr;
        logic [NREG-1:0] inc;
        logic [NREG-1:0] clr;
        logic [W-1:0]    bin;
        logic            busy;
        logic            done;
    } exp_t;

    logic              clk = 1'b0;
    logic              RST;
    logic              REQ;
    logic [1:0]        OP;
    logic [2:0]        SRC;
    logic [2:0]        DST;
    logic [NREG*W-1:0] RDATA;
    logic [NREG-1:0]   LDBUS, WR, INC, CLR;
    logic [W-1:0]      BIN;
    logic              BUSY, DONE;
`ifdef XFER_STATS_EN
    logic [15:0]       XFER_CNT;
`endif

    int         n_tests = 0;
    int         n_fail  = 0;
    logic [W-1:0] bin_m = '0;   // model of the value BIN must hold
    logic [15:0]  cnt_m = '0;   // model of completed transfers
    exp_t       exp_q[$];

    bus_xfer_ctrl #(.NREG(NREG), .W(W)) dut (
        .clk      (clk),
        .RST      (RST),
        .REQ      (REQ),
        .OP       (OP),
        .SRC      (SRC),
        .DST      (DST),
        .RDATA    (RDATA),
        .LDBUS    (LDBUS),
        .WR       (WR),
        .INC      (INC),
        .CLR      (CLR),
        .BIN      (BIN),
        .BUSY     (BUSY),
        .DONE     (DONE)
`ifdef XFER_STATS_EN
        ,
        .XFER_CNT (XFER_CNT)
`endif
    );

    always #50 clk = ~clk;

    initial begin
        #10_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_tests++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
        end
    endtask

    task automatic check_exp(input string tag, input exp_t e);
        check({tag, ".LDBUS"}, 32'(LDBUS), 32'(e.ldbus));
        check({tag, ".WR"},    32'(WR),    32'(e.wr));
        check({tag, ".INC"},   32'(INC),   32'(e.inc));
        check({tag, ".CLR"},   32'(CLR),   32'(e.clr));
        check({tag, ".BIN"},   32'(BIN),   32'(e.bin));
        check({tag, ".BUSY"},  32'(BUSY),  32'(e.busy));
        check({tag, ".DONE"},  32'(DONE),  32'(e.done));
    endtask

    function automatic exp_t quiet(input logic [W-1:0] bin, input logic busy);
        exp_t e;
        e.ldbus = '0; e.wr = '0; e.inc = '0; e.clr = '0;
        e.bin = bin; e.busy = busy; e.done = 1'b0;
        return e;
    endfunction

    // One transfer from an idle falling edge to the next idle falling edge.
    // hold keeps REQ high throughout (it must be ignored while busy); a
    // non-negative abort_at asserts RST mid-cycle after that busy cycle.
    task automatic run_xfer(input logic [1:0] op, input int src, input int dst,
                            input bit hold, input int abort_at);
        logic [W-1:0]    val;
        logic [NREG-1:0] s1, d1;
        exp_t            e;
        string           tag;
        tag = $sformatf("op%0d s%0d d%0d", op, src, dst);
`ifdef XFER_STATS_EN
        check({tag, ".XFER_CNT"}, 32'(XFER_CNT), 32'(cnt_m));
`endif
        check_exp({tag, " idle"}, quiet(bin_m, 1'b0));

        // Expected per-cycle behaviour of the requested operation.
        val = RDATA[src*W +: W];
        s1  = NREG'(1) << src;
        d1  = NREG'(1) << dst;
        exp_q.delete();
        e = quiet(bin_m, 1'b1);
        if (op == 2'b00 || op == 2'b11) begin
            e.ldbus = s1; exp_q.push_back(e); e.ldbus = '0;
            exp_q.push_back(e);
            e.bin = val; e.wr = d1; exp_q.push_back(e); e.wr = '0;
            if (op == 2'b11) begin
                e.inc = s1; exp_q.push_back(e); e.inc = '0;
            end
        end else if (op == 2'b01) begin
            e.inc = d1; exp_q.push_back(e); e.inc = '0;
        end else begin
            e.clr = d1; exp_q.push_back(e); e.clr = '0;
        end
        e.done = 1'b1;
        exp_q.push_back(e);

        REQ = 1'b1; OP = op; SRC = 3'(src); DST = 3'(dst);
        for (int k = 0; k < exp_q.size(); k++) begin
            @(negedge clk);
            check_exp($sformatf("%s c%0d", tag, k + 1), exp_q[k]);
            if (k == abort_at) begin
                #10 RST = 1'b1;
                #1 check_exp($sformatf("%s abort c%0d", tag, k + 1), quiet('0, 1'b0));
                @(negedge clk);
                RST = 1'b0; REQ = 1'b0;
                bin_m = '0;
                cnt_m = '0;
                for (int j = 0; j < 4; j++) begin
                    @(negedge clk);
                    check_exp($sformatf("%s post-abort %0d", tag, j), quiet('0, 1'b0));
                end
                return;
            end
            // Scramble the inputs while busy; none of it may matter.
            if (k == exp_q.size() - 1) REQ = hold;
            else REQ = hold ? 1'b1 : 1'($urandom);
            OP  = 2'($urandom);
            SRC = 3'($urandom);
            DST = 3'($urandom);
        end
        bin_m = exp_q[exp_q.size() - 1].bin;
        cnt_m = cnt_m + 16'd1;
        @(negedge clk);
    endtask

    initial begin
        RST = 1'b0; REQ = 1'b0; OP = '0; SRC = '0; DST = '0; RDATA = '0;
        #1 RST = 1'b1;
        #1 check_exp("reset async", quiet('0, 1'b0));
        @(negedge clk);
        @(negedge clk);
        check_exp("reset held", quiet('0, 1'b0));
        RST = 1'b0;
        @(negedge clk);

        // Move R3 (35) to R5.
        RDATA[3*W +: W] = 16'd35;
        run_xfer(2'b00, 3, 5, 1'b0, -1);
        // Move R2 (0xFFFF) to R4, then increment R2.
        RDATA[2*W +: W] = 16'hFFFF;
        run_xfer(2'b11, 2, 4, 1'b0, -1);
        // Increment R7, then clear R0.
        run_xfer(2'b01, 1, 7, 1'b0, -1);
        run_xfer(2'b10, 6, 0, 1'b0, -1);
        // Self-moves.
        RDATA[6*W +: W] = 16'h1234;
        run_xfer(2'b00, 6, 6, 1'b0, -1);
        run_xfer(2'b11, 1, 1, 1'b0, -1);
        // REQ held high through a move, then back-to-back second transfer.
        RDATA[1*W +: W] = 16'hA5C3;
        run_xfer(2'b00, 1, 6, 1'b1, -1);
        run_xfer(2'b10, 4, 3, 1'b1, -1);
        // Reset during LOAD, then during WRITE.
        run_xfer(2'b11, 0, 2, 1'b0, 0);
        RDATA[3*W +: W] = 16'd99;
        run_xfer(2'b00, 3, 5, 1'b0, 2);
        run_xfer(2'b00, 3, 5, 1'b0, -1);

        // Randomized transfers.
        for (int t = 0; t < 200; t++) begin
            int ab;
            for (int i = 0; i < NREG; i++) RDATA[i*W +: W] = 16'($urandom);
            ab = ($urandom_range(0, 15) == 0) ? int'($urandom_range(0, 3)) : -1;
            run_xfer(2'($urandom), int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
                     ($urandom_range(0, 3) == 0), ab);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
